// File: rtl/cache_sram_arbiter_pkg.sv
// Shared definitions for the cache-to-bridge sram-like arbiter.
// Holds FSM/owner codes and the sram-like port bundle layout.
package cache_sram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADDR   = 2'd1,
    ST_WAIT_D = 2'd2
  } state_t;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam int SRAM_AW = 32;
  localparam int SRAM_DW = 32;
  localparam int SRAM_SW = 2;

  typedef struct packed {
    logic               wr;
    logic [SRAM_SW-1:0] size;
    logic [SRAM_AW-1:0] addr;
    logic [SRAM_DW-1:0] wdata;
  } sram_cmd_t;

endpackage

// File: rtl/cache_sram_arbiter_starve_pick.sv
// Priority function: data wins by default, inst wins alone
// or once it has lost MAX_WAIT arbitrations in a row.
module arb_starve_pick
  import cache_sram_arbiter_pkg::*;
#(
  parameter int MAX_WAIT  = 4,
  parameter int CNT_WIDTH = 3
) (
  input  logic                 inst_req,
  input  logic                 data_req,
  input  logic [CNT_WIDTH-1:0] starve_cnt,
  output logic                 sel
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_WAIT);

  logic starved;

  assign starved = (MAX_WAIT != 0) && (starve_cnt == CNT_MAX);

  always_comb begin
    sel = OWN_DATA;
    if (inst_req && (!data_req || starved)) sel = OWN_INST;
  end

endmodule

// File: rtl/cache_sram_arbiter.sv
// Shares one sram-like bridge port between i-cache and d-cache,
// one outstanding transaction, grant locked until data_ok.
module cache_sram_arbiter
  import cache_sram_arbiter_pkg::*;
#(
  parameter int MAX_WAIT  = 4,
  parameter int CNT_WIDTH = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inst_req,
  input  logic         inst_wr,
  input  logic [1:0]   inst_size,
  input  logic [31:0]  inst_addr,
  input  logic [31:0]  inst_wdata,
  output logic [31:0]  inst_rdata,
  output logic         inst_addr_ok,
  output logic         inst_data_ok,
  input  logic         data_req,
  input  logic         data_wr,
  input  logic [1:0]   data_size,
  input  logic [31:0]  data_addr,
  input  logic [31:0]  data_wdata,
  output logic [31:0]  data_rdata,
  output logic         data_addr_ok,
  output logic         data_data_ok,
  output logic         out_req,
  output logic         out_wr,
  output logic [1:0]   out_size,
  output logic [31:0]  out_addr,
  output logic [31:0]  out_wdata,
  input  logic [31:0]  out_rdata,
  input  logic         out_addr_ok,
  input  logic         out_data_ok,
  output logic         busy,
  output logic         owner
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_WAIT);

  state_t               state;
  state_t               state_nx;
  logic                 owner_nx;
  logic [CNT_WIDTH-1:0] starve_cnt;
  logic [CNT_WIDTH-1:0] cnt_nx;
  logic                 sel;
  logic                 cur;
  logic                 cur_req;
  logic                 any_req;
  logic                 dok;
  sram_cmd_t            inst_cmd;
  sram_cmd_t            data_cmd;
  sram_cmd_t            cur_cmd;

  arb_starve_pick #(
    .MAX_WAIT  (MAX_WAIT),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_pick (
    .inst_req   (inst_req),
    .data_req   (data_req),
    .starve_cnt (starve_cnt),
    .sel        (sel)
  );

  assign any_req  = inst_req | data_req;
  assign cur      = (state == ST_IDLE) ? sel : owner;
  assign cur_req  = (cur == OWN_DATA) ? data_req : inst_req;
  assign inst_cmd = {inst_wr, inst_size, inst_addr, inst_wdata};
  assign data_cmd = {data_wr, data_size, data_addr, data_wdata};
  assign cur_cmd  = (cur == OWN_DATA) ? data_cmd : inst_cmd;

  assign out_wr    = cur_cmd.wr;
  assign out_size  = cur_cmd.size;
  assign out_addr  = cur_cmd.addr;
  assign out_wdata = cur_cmd.wdata;
  assign out_req   = !rst && (state != ST_WAIT_D) && cur_req;

  assign inst_addr_ok = out_req && out_addr_ok && (cur == OWN_INST);
  assign data_addr_ok = out_req && out_addr_ok && (cur == OWN_DATA);

  // data_ok outside WAIT_D is a stray pulse and is dropped
  assign dok          = !rst && (state == ST_WAIT_D) && out_data_ok;
  assign inst_data_ok = dok && (owner == OWN_INST);
  assign data_data_ok = dok && (owner == OWN_DATA);

  assign inst_rdata = out_rdata;
  assign data_rdata = out_rdata;
  assign busy       = !rst && (state != ST_IDLE);

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    cnt_nx   = starve_cnt;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          state_nx = out_addr_ok ? ST_WAIT_D : ST_ADDR;
          owner_nx = sel;
          if (sel == OWN_INST) begin
            cnt_nx = '0;
          end else if (inst_req && starve_cnt != CNT_MAX) begin
            cnt_nx = starve_cnt + CNT_WIDTH'(1);
          end
        end
      end
      ST_ADDR: begin
        if (out_addr_ok) state_nx = ST_WAIT_D;
      end
      ST_WAIT_D: begin
        if (out_data_ok) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= OWN_INST;
      starve_cnt <= '0;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      starve_cnt <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_cache_sram_arbiter.sv
// Scenario bench for cache_sram_arbiter with a transaction-level
// reference model driving randomized masters and bridge.
module tb_cache_sram_arbiter;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, out_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [31:0] inst_rdata, data_rdata, out_addr, out_wdata, out_rdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic        out_req, out_wr, out_addr_ok, out_data_ok, busy, owner;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cache_sram_arbiter #(.MAX_WAIT(MW), .CNT_WIDTH(3)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .out_req(out_req), .out_wr(out_wr), .out_size(out_size),
    .out_addr(out_addr), .out_wdata(out_wdata), .out_rdata(out_rdata),
    .out_addr_ok(out_addr_ok), .out_data_ok(out_data_ok),
    .busy(busy), .owner(owner)
  );

  task automatic idle_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2;
    inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 2'd2;
    data_addr = 0; data_wdata = 0;
    out_rdata = 0; out_addr_ok = 0; out_data_ok = 0;
  endtask

  task automatic go();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; inst_req = 1; data_req = 1;
    out_addr_ok = 1; out_data_ok = 1;
    smp();
    checks++;
    if ({out_req, inst_addr_ok, data_addr_ok, inst_data_ok,
         data_data_ok, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_force: got %b want 000000",
        {out_req, inst_addr_ok, data_addr_ok, inst_data_ok,
         data_data_ok, busy});
    end
    go(); rst = 0; idle_inputs();
    smp();
    checks++;
    if ({busy, owner} !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: busy/owner got %b want 00", {busy, owner});
    end
  endtask

  task automatic test_single_inst();
    go(); inst_req = 1; inst_addr = 32'hBFC00000; out_addr_ok = 1;
    smp();
    checks++;
    if ({out_req, inst_addr_ok, data_addr_ok, busy} !== 4'b1100 ||
        out_addr !== 32'hBFC00000) begin
      errors++;
      $display("FAIL single_c0: got %b/%h want 1100/bfc00000",
        {out_req, inst_addr_ok, data_addr_ok, busy}, out_addr);
    end
    for (int c = 1; c < 3; c++) begin
      go(); inst_req = 0; out_addr_ok = 0;
      smp();
      checks++;
      if ({busy, out_req, inst_data_ok, data_data_ok, data_addr_ok}
          !== 5'b10000) begin
        errors++;
        $display("FAIL single_wait%0d: got %b want 10000", c,
          {busy, out_req, inst_data_ok, data_data_ok, data_addr_ok});
      end
    end
    go(); out_data_ok = 1; out_rdata = 32'h3C08BFAF;
    smp();
    checks++;
    if ({busy, inst_data_ok, data_data_ok} !== 3'b110 ||
        inst_rdata !== 32'h3C08BFAF) begin
      errors++;
      $display("FAIL single_c3: got %b/%h want 110/3c08bfaf",
        {busy, inst_data_ok, data_data_ok}, inst_rdata);
    end
    go(); idle_inputs();
    smp();
    checks++;
    if ({busy, owner} !== 2'b00) begin
      errors++;
      $display("FAIL single_end: busy/owner got %b want 00", {busy, owner});
    end
  endtask

  task automatic test_simultaneous();
    go();
    inst_req = 1; inst_addr = 32'h00000100;
    data_req = 1; data_wr = 1; data_addr = 32'h80000010;
    data_wdata = 32'hDEADBEEF; data_size = 2'd2; out_addr_ok = 1;
    smp();
    checks++;
    if ({out_wr, data_addr_ok, inst_addr_ok} !== 3'b110 ||
        out_wdata !== 32'hDEADBEEF || out_addr !== 32'h80000010 ||
        out_size !== 2'd2) begin
      errors++;
      $display("FAIL simul_data: got %b %h %h want 110 deadbeef 80000010",
        {out_wr, data_addr_ok, inst_addr_ok}, out_wdata, out_addr);
    end
    go(); data_req = 0; out_addr_ok = 0; out_data_ok = 1;
    smp();
    checks++;
    if ({data_data_ok, inst_data_ok, owner} !== 3'b101 ||
        dut.starve_cnt !== 3'd1) begin
      errors++;
      $display("FAIL simul_data_ok: got %b cnt %0d want 101 cnt 1",
        {data_data_ok, inst_data_ok, owner}, dut.starve_cnt);
    end
    go(); out_data_ok = 0; out_addr_ok = 1;
    smp();
    checks++;
    if ({inst_addr_ok, out_wr} !== 2'b10 || out_addr !== 32'h00000100) begin
      errors++;
      $display("FAIL simul_inst: got %b %h want 10 00000100",
        {inst_addr_ok, out_wr}, out_addr);
    end
    go(); inst_req = 0; out_addr_ok = 0; out_data_ok = 1;
    smp();
    checks++;
    if (inst_data_ok !== 1'b1 || dut.starve_cnt !== 3'd0) begin
      errors++;
      $display("FAIL simul_inst_ok: got %b cnt %0d want 1 cnt 0",
        inst_data_ok, dut.starve_cnt);
    end
    go(); idle_inputs();
  endtask

  task automatic test_starvation();
    int l = 0;
    for (int k = 0; k < 6; k++) begin
      logic exp_i;
      exp_i = (l == MW);
      go();
      inst_req = 1; data_req = 1; inst_addr = 32'h1000 + k;
      data_addr = 32'h2000 + k; data_wr = 0;
      out_addr_ok = 1; out_data_ok = 0;
      smp();
      checks++;
      if ({inst_addr_ok, data_addr_ok} !== {exp_i, ~exp_i} ||
          out_addr !== (exp_i ? inst_addr : data_addr)) begin
        errors++;
        $display("FAIL starve_grant%0d: got %b %h want %b", k,
          {inst_addr_ok, data_addr_ok}, out_addr, {exp_i, ~exp_i});
      end
      l = exp_i ? 0 : ((l < MW) ? l + 1 : l);
      go(); out_addr_ok = 0; out_data_ok = 1;
      smp();
      checks++;
      if ({inst_data_ok, data_data_ok} !== {exp_i, ~exp_i} ||
          dut.starve_cnt !== 3'(l)) begin
        errors++;
        $display("FAIL starve_done%0d: got %b cnt %0d want %b cnt %0d", k,
          {inst_data_ok, data_data_ok}, dut.starve_cnt, {exp_i, ~exp_i}, l);
      end
    end
    go(); idle_inputs();
  endtask

  task automatic test_grant_lock();
    go(); data_req = 1; data_addr = 32'hA0000040;
    smp();
    checks++;
    if ({data_addr_ok, busy} !== 2'b00 || out_addr !== 32'hA0000040) begin
      errors++;
      $display("FAIL lock_c0: got %b %h want 00 a0000040",
        {data_addr_ok, busy}, out_addr);
    end
    for (int c = 1; c < 4; c++) begin
      go(); inst_req = 1; inst_addr = 32'h00000200; out_addr_ok = (c == 3);
      smp();
      checks++;
      if ({busy, inst_addr_ok, data_addr_ok} !== {2'b10, c == 3} ||
          out_addr !== 32'hA0000040) begin
        errors++;
        $display("FAIL lock_c%0d: got %b %h want %b a0000040", c,
          {busy, inst_addr_ok, data_addr_ok}, out_addr, {2'b10, c == 3});
      end
    end
    go(); data_req = 0; out_addr_ok = 0;
    smp();
    checks++;
    if ({out_req, inst_addr_ok} !== 2'b00) begin
      errors++;
      $display("FAIL lock_wait: got %b want 00", {out_req, inst_addr_ok});
    end
    go(); out_data_ok = 1;
    smp();
    checks++;
    if ({data_data_ok, inst_data_ok, inst_addr_ok} !== 3'b100) begin
      errors++;
      $display("FAIL lock_dok: got %b want 100",
        {data_data_ok, inst_data_ok, inst_addr_ok});
    end
    go(); out_data_ok = 0; out_addr_ok = 1;
    smp();
    checks++;
    if (inst_addr_ok !== 1'b1 || out_addr !== 32'h00000200) begin
      errors++;
      $display("FAIL lock_inst: got %b %h want 1 00000200",
        inst_addr_ok, out_addr);
    end
    go(); inst_req = 0; out_addr_ok = 0; out_data_ok = 1;
    smp();
    go(); idle_inputs();
  endtask

  task automatic test_stray();
    go(); out_data_ok = 1;
    smp();
    checks++;
    if ({inst_data_ok, data_data_ok, busy} !== 3'b000) begin
      errors++;
      $display("FAIL stray_dok: got %b want 000",
        {inst_data_ok, data_data_ok, busy});
    end
    go(); out_data_ok = 0;
    smp();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL stray_idle: busy got %b want 0", busy);
    end
  endtask

  task automatic test_async_reset();
    go(); inst_req = 1; data_req = 1; data_addr = 32'h80000020;
    out_addr_ok = 1;
    smp();
    go(); inst_req = 0; data_req = 0; out_addr_ok = 0;
    smp();
    checks++;
    if (busy !== 1'b1 || dut.starve_cnt !== 3'd1) begin
      errors++;
      $display("FAIL areset_pre: busy %b cnt %0d want 1 cnt 1",
        busy, dut.starve_cnt);
    end
    go(); out_data_ok = 1; inst_req = 1;
    #2 rst = 1;
    #1;
    checks++;
    if ({out_req, inst_addr_ok, data_addr_ok, inst_data_ok,
         data_data_ok, busy} !== 6'b0) begin
      errors++;
      $display("FAIL areset_mid: got %b want 000000",
        {out_req, inst_addr_ok, data_addr_ok, inst_data_ok,
         data_data_ok, busy});
    end
    go(); rst = 0; idle_inputs();
    smp();
    checks++;
    if ({busy, owner} !== 2'b00 || dut.starve_cnt !== 3'd0) begin
      errors++;
      $display("FAIL areset_post: got %b cnt %0d want 00 cnt 0",
        {busy, owner}, dut.starve_cnt);
    end
    go(); inst_req = 1; inst_addr = 32'hBFC00010; out_addr_ok = 1;
    smp();
    checks++;
    if (inst_addr_ok !== 1'b1 || out_addr !== 32'hBFC00010) begin
      errors++;
      $display("FAIL areset_grant: got %b %h want 1 bfc00010",
        inst_addr_ok, out_addr);
    end
    go(); inst_req = 0; out_addr_ok = 0; out_data_ok = 1;
    smp();
    checks++;
    if (inst_data_ok !== 1'b1) begin
      errors++;
      $display("FAIL areset_dok: got %b want 1", inst_data_ok);
    end
    go(); idle_inputs();
  endtask

  task automatic test_random();
    int          ph = 0;
    int          l = 0;
    logic        mo = 0;
    logic        ir = 0, dr = 0, win, cur, ereq, ab, db;
    logic [31:0] exp_addr;
    go(); rst = 1; idle_inputs();
    go(); rst = 0;
    for (int n = 0; n < 400; n++) begin
      go();
      if (!ir && $urandom_range(0, 2) == 0) begin
        ir = 1; inst_addr = $urandom; inst_wr = 0;
        inst_size = 2'($urandom_range(0, 2));
      end
      if (!dr && $urandom_range(0, 1) == 0) begin
        dr = 1; data_addr = $urandom; data_wdata = $urandom;
        data_wr = 1'($urandom); data_size = 2'($urandom_range(0, 2));
      end
      inst_req = ir; data_req = dr;
      if (ph == 0) begin
        if (ir && dr) win = (MW != 0 && l == MW) ? 1'b0 : 1'b1;
        else win = ir ? 1'b0 : 1'b1;
        cur = win; ereq = ir | dr;
      end else begin
        cur = mo; ereq = (ph == 1) ? (mo ? dr : ir) : 1'b0;
      end
      ab = ereq && ($urandom_range(0, 1) == 1);
      db = ($urandom_range(0, 2) == 0);
      out_addr_ok = ab; out_data_ok = db; out_rdata = $urandom;
      exp_addr = cur ? data_addr : inst_addr;
      smp();
      checks++;
      if (out_req !== ereq || busy !== (ph != 0) || owner !== mo ||
          (ereq && out_addr !== exp_addr)) begin
        errors++;
        $display("FAIL rand_fwd%0d: req %b busy %b own %b addr %h want %b %b %b %h",
          n, out_req, busy, owner, out_addr, ereq, ph != 0, mo, exp_addr);
      end
      checks++;
      if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !==
          {ab && !cur, ab && cur, ph == 2 && db && !mo, ph == 2 && db && mo}) begin
        errors++;
        $display("FAIL rand_hs%0d: got %b want %b", n,
          {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok},
          {ab && !cur, ab && cur, ph == 2 && db && !mo, ph == 2 && db && mo});
      end
      if (ph == 2 && db) begin
        checks++;
        if ((mo ? data_rdata : inst_rdata) !== out_rdata) begin
          errors++;
          $display("FAIL rand_rdata%0d: got %h want %h", n,
            mo ? data_rdata : inst_rdata, out_rdata);
        end
      end
      if (ph == 0) begin
        if (ir || dr) begin
          mo = win;
          if (!win) l = 0;
          else if (ir && l < MW) l++;
          ph = ab ? 2 : 1;
        end
      end else if (ph == 1) begin
        if (ab) ph = 2;
      end else if (db) begin
        ph = 0;
      end
      if (ab && !cur) ir = 0;
      if (ab && cur) dr = 0;
    end
    go(); idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_inst();
    test_simultaneous();
    test_starvation();
    test_grant_lock();
    test_stray();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_sram_arbiter.md
Name: cache_sram_arbiter

Overview:
- Shares the single sram-like port of the AXI bridge between the instruction cache (miss refills) and the data cache (miss refills and write-through stores).
- Sits between both caches and the sram-to-AXI converter.
- Allows one outstanding transaction at a time.
- Default priority goes to data, with a starvation guard that forces an instruction grant after MAX_WAIT consecutive losses.

Parameters:
- MAX_WAIT, 4, consecutive arbitration losses by inst before inst is forced to win; 0 = strict data priority, no guard.
- CNT_WIDTH, 3, width of the starvation counter; must hold MAX_WAIT.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- inst_req/inst_wr  in  1/1  inst master request and write flag
- inst_size  in  2  inst transfer size
- inst_addr/inst_wdata  in  32/32  inst address and write data
- inst_rdata  out  32  read data to inst master
- inst_addr_ok/inst_data_ok  out  1/1  handshakes to inst master
- data_req/data_wr  in  1/1  data master request and write flag
- data_size  in  2  data transfer size
- data_addr/data_wdata  in  32/32  data address and write data
- data_rdata  out  32  read data to data master
- data_addr_ok/data_data_ok  out  1/1  handshakes to data master
- out_req/out_wr  out  1/1  request and write flag to bridge
- out_size  out  2  transfer size to bridge
- out_addr/out_wdata  out  32/32  address and write data to bridge
- out_rdata  in  32  read data from bridge
- out_addr_ok/out_data_ok  in  1/1  handshakes from bridge
- busy  out  1  high in ADDR or WAIT_D
- owner  out  1  current or last grant, 0 = inst, 1 = data

Behaviour:
- State register: IDLE, ADDR, WAIT_D. Registers owner and starve_cnt. All reset asynchronously: state=IDLE, owner=0, starve_cnt=0.
- Selection in IDLE (combinational, sel):
  - Only one master requesting: that master wins.
  - Both requesting: inst wins if MAX_WAIT!=0 and starve_cnt==MAX_WAIT; otherwise data wins.
- Request forwarding:
  - In IDLE, out_req is the selected master's req with zero added latency; out_wr/size/addr/wdata mux from sel.
  - In ADDR, the same signals mux from the owner register.
  - In WAIT_D, out_req=0 and the other out_* signals keep the owner mux.
- out_addr_ok is routed only to the master currently driving out_req. The other master's addr_ok=0.
- out_data_ok is routed only to owner, and only in WAIT_D. A data_ok seen in IDLE/ADDR is ignored and never forwarded.
- inst_rdata and data_rdata are both driven from out_rdata (broadcast). Each master qualifies it with its own data_ok.
- Transitions:
  - IDLE, any req and out_addr_ok -> WAIT_D, owner<=sel.
  - IDLE, any req and no addr_ok -> ADDR, owner<=sel. The grant is locked; no re-arbitration until data_ok, even if the other master raises req.
  - IDLE, no req: stay; owner holds.
  - ADDR, out_addr_ok -> WAIT_D.
  - WAIT_D, out_data_ok -> IDLE. The next arbitration happens in the following cycle, so the minimum gap between transactions is 1 cycle.
- starve_cnt update, once per grant, on the IDLE exit:
  - data granted while inst_req=1: starve_cnt+1, saturating at MAX_WAIT.
  - inst granted: starve_cnt=0.
  - data granted with inst_req=0: starve_cnt unchanged.
- Masters follow sram-like rules: req held with stable fields until addr_ok. If a master drops req before addr_ok, the arbiter keeps forwarding it; out_req then falls, and the arbiter stays in ADDR until a later addr_ok. This is a master protocol violation; no recovery is provided.
- While rst=1, force out_req, all addr_ok and all data_ok to 0, and busy=0. Reset mid-transaction abandons it: the bridge must be reset concurrently.

Decomposition:
- Shared package: state encodings (ST_IDLE=2'd0, ST_ADDR=2'd1, ST_WAIT_D=2'd2) and owner codes (OWN_INST=1'b0, OWN_DATA=1'b1). The sram-like port bundle width constants go in the same package for reuse by the d_cache and bridge glue.
- One natural sub-module: arb_starve_pick. It is combinational: inputs inst_req, data_req, starve_cnt; output sel. Keeping it separate allows exhaustive unit testing of the priority function.

Test Plan:
- Single inst read, addr 0xBFC00000, addr_ok in cycle 0, data_ok in cycle 3 with rdata 0x3C08BFAF:
  - inst_addr_ok=1 in cycle 0, inst_data_ok=1 in cycle 3 with inst_rdata=0x3C08BFAF.
  - data_* handshakes stay 0 throughout; busy is high in cycles 1-3.
- Simultaneous inst read 0x00000100 and data write 0x80000010 (wdata 0xDEADBEEF, size 2), starve_cnt=0:
  - Data is forwarded first with out_wr=1 and out_wdata=0xDEADBEEF; starve_cnt becomes 1.
  - After data_ok, inst is forwarded with out_addr=0x00000100; starve_cnt becomes 0.
- Starvation, MAX_WAIT=4: data_req and inst_req held continuously, bridge responds in 2 cycles:
  - Grants are data ×4, then inst, then data again.
  - starve_cnt sequence is 1,2,3,4,0.
- Grant lock: data selected, bridge delays addr_ok by 3 cycles, inst_req rises in the 2nd cycle:
  - out_addr stays equal to data_addr; inst_addr_ok=0 until data's data_ok.
  - Inst is granted in the cycle after IDLE is re-entered.
- Stray handshake: out_data_ok pulsed in IDLE with no req -> no master data_ok, state remains IDLE.
- Async reset during WAIT_D (rst asserted mid-cycle, no clock edge) -> out_req and all handshake outputs go 0 immediately. After release, state=IDLE and starve_cnt=0, and a new inst request is granted normally.
